// File: rtl/bool_fn_extractor_pkg.sv
// Shared definitions for the boolean-function extractor: state encoding and
// the widths of the recovered truth table and sample counter.
package bool_fn_extractor_pkg;

   localparam int BFN_W = 4;
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2,
      ERROR   = 2'd3
   } state_t;

endpackage

// File: rtl/bool_fn_extractor_reduce.sv
// Per-word reduction: for every select value {b[i],a[i]}, flag whether any bit
// position showed y=1 (hit1) or y=0 (hit0).
module bool_fn_reduce
   import bool_fn_extractor_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [W-1:0]     y,
   output logic [BFN_W-1:0] hit0,
   output logic [BFN_W-1:0] hit1
);

   always_comb begin
      hit0 = '0;
      hit1 = '0;
      for (int i = 0; i < W; i++) begin
         if (y[i]) hit1[{b[i], a[i]}] = 1'b1;
         else      hit0[{b[i], a[i]}] = 1'b1;
      end
   end

endmodule

// File: rtl/bool_fn_extractor.sv
// Observes operand/result words of a per-bit 4:1 truth-table unit and recovers
// its 4-bit function code, flagging contradictory observations.
module bool_fn_extractor
   import bool_fn_extractor_pkg::*;
#(
   parameter int W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [W-1:0]     y,
   input  logic             finish,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BFN_W-1:0] bfn,
   output logic [BFN_W-1:0] known,
   output logic             conflict,
   output logic [CNT_W-1:0] count
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   state_t             state_p0, state_n;
   logic [BFN_W-1:0]   seen0_p0, seen1_p0, seen0_n, seen1_n;
   logic [CNT_W-1:0]   count_p0, count_n;
   logic [BFN_W-1:0]   hit0, hit1;
   logic               collecting, accept;

   bool_fn_reduce #(.W(W)) u_reduce (
      .a    (a),
      .b    (b),
      .y    (y),
      .hit0 (hit0),
      .hit1 (hit1)
   );

   assign collecting = (state_p0 == IDLE) || (state_p0 == COLLECT);
   assign accept     = in_valid && collecting && !clear;

   // Outputs are forced to their idle values while reset is held.
   assign in_ready  = reset || (collecting && !clear);
   assign out_valid = !reset && !collecting;
   assign bfn       = reset ? '0 : (seen1_p0 & ~seen0_p0);
   assign known     = reset ? '0 : (seen1_p0 | seen0_p0);
   assign conflict  = !reset && (state_p0 == ERROR) && |(seen0_p0 & seen1_p0);
   assign count     = reset ? '0 : count_p0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_p0 <= IDLE;
         seen0_p0 <= '0;
         seen1_p0 <= '0;
         count_p0 <= '0;
      end else begin
         state_p0 <= state_n;
         seen0_p0 <= seen0_n;
         seen1_p0 <= seen1_n;
         count_p0 <= count_n;
      end
   end

   always_comb begin
      state_n = state_p0;
      seen0_n = seen0_p0;
      seen1_n = seen1_p0;
      count_n = count_p0;
      case (state_p0)
         IDLE, COLLECT: begin
            if (accept) begin
               seen0_n = seen0_p0 | hit0;
               seen1_n = seen1_p0 | hit1;
               count_n = sat_inc(count_p0);
            end
            // Decide on the updated masks so the same-cycle sample is included.
            if (accept || finish) begin
               if (|(seen0_n & seen1_n))                state_n = ERROR;
               else if ((&(seen0_n | seen1_n)) || finish) state_n = DONE;
               else                                      state_n = COLLECT;
            end
         end
         DONE, ERROR: begin
            if (out_ready) begin
               state_n = IDLE;
               seen0_n = '0;
               seen1_n = '0;
               count_n = '0;
            end
         end
         default: state_n = IDLE;
      endcase
      if (clear) begin
         state_n = IDLE;
         seen0_n = '0;
         seen1_n = '0;
         count_n = '0;
      end
   end

endmodule

// File: doc/bool_fn_extractor.md
BOOL_FN_EXTRACTOR -- requirements
Module: bool_fn_extractor

Interface
REQ-001 Parameter W, default 32, operand/result word width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 in_valid  input  1  sample word on a/b/y is valid.
REQ-005 in_ready  output  1  block accepts a sample this cycle; transfer when in_valid & in_ready.
REQ-006 a  input  W  operand A word of an observed boolean-unit operation.
REQ-007 b  input  W  operand B word.
REQ-008 y  input  W  observed result word.
REQ-009 finish  input  1  end the current collection and force a result with a partial mask.
REQ-010 clear  input  1  discard all collected state and return to IDLE.
REQ-011 out_valid  output  1  result fields are valid.
REQ-012 out_ready  input  1  consumer takes the result; transfer when out_valid & out_ready.
REQ-013 bfn  output  4  recovered truth table; bit k = Y for select k = {B,A}.
REQ-014 known  output  4  bit k set when select k was observed at least once.
REQ-015 conflict  output  1  some select was observed with both Y=0 and Y=1.
REQ-016 count  output  8  accepted samples in this collection, saturating at 255.

Function
REQ-017 The block infers the 4-bit function code of a per-bit 4:1 truth-table unit: for each bit i, sel_i = {b[i],a[i]} and the observed value is y[i].
REQ-018 Per word: hit1[k] = OR over i of (sel_i==k & y[i]); hit0[k] = OR over i of (sel_i==k & ~y[i]).
REQ-019 On each accepted sample: seen1 |= hit1; seen0 |= hit0; count increments, saturating.
REQ-020 known = seen0 | seen1; bfn = seen1 & ~seen0; conflict = |(seen0 & seen1).
REQ-021 States: IDLE, COLLECT, DONE, ERROR.
REQ-022 IDLE: in_ready=1; an accepted sample moves to COLLECT, or directly to DONE/ERROR per REQ-023/REQ-024.
REQ-023 COLLECT: in_ready=1; after an accept, move to ERROR if the updated conflict is 1, else to DONE if the updated known = 4'b1111, else stay in COLLECT.
REQ-024 Conflict takes priority over completion when both occur on the same sample.
REQ-025 finish in IDLE or COLLECT moves to DONE; a sample accepted in the same cycle is included first, and REQ-024 priority still applies.
REQ-026 DONE and ERROR: in_ready=0, out_valid=1, all outputs held stable until the out handshake.
REQ-027 conflict=1 in ERROR only; bfn and known are still reported in ERROR.
REQ-028 On the out handshake, the next state is IDLE and seen0, seen1 and count clear to 0.
REQ-029 Latency: out_valid rises in the cycle after the accept (or finish) that causes DONE/ERROR.
REQ-030 clear in any state takes IDLE and zeroes all state next cycle; it overrides in_valid, finish and out_ready.
REQ-031 in_ready = 0 in any cycle where clear = 1.
REQ-032 A full word with all bits at one select sets only that known bit.
REQ-033 count saturates at 255 and never wraps.

Reset
REQ-034 Reset takes priority over every other input and forces IDLE, seen0=seen1=0, count=0.
REQ-035 Output values while reset is asserted and the cycle after: out_valid=0, in_ready=1, bfn=0, known=0, conflict=0, count=0.
REQ-036 Reset mid-collection or while out_valid=1 discards the result without a handshake.

Structure
REQ-037 State encoding (IDLE=0, COLLECT=1, DONE=2, ERROR=3), BFN width 4 and the count width 8 are defined in the shared package used by the ALU blocks.
REQ-038 The per-word reduction (REQ-018) is a purely combinational sub-module, bool_fn_reduce, with ports a, b, y, hit0[3:0] and hit1[3:0].
REQ-039 The top level holds only registers, the FSM and the handshake logic.

Verification
REQ-040 AND sample: a=0x0000FFFF, b=0x00FF00FF, y=0x000000FF -> next cycle out_valid=1, bfn=4'b1000, known=4'b1111, conflict=0, count=1.
REQ-041 OR then XOR: same a/b with y=0x00FFFFFF -> bfn=4'b1110; after handshake, y=0x00FFFF00 -> bfn=4'b0110.
REQ-042 Partial sample: a=b=y=0xFFFFFFFF, then finish -> known=4'b1000, bfn=4'b1000, count=1; in_ready=0 until out_ready=1.
REQ-043 Conflict sample: a=b=0, y=0x00000001 -> state ERROR, conflict=1, known=4'b0001, bfn=4'b0000.
REQ-044 Control precedence: clear asserted with in_valid=1 -> sample dropped, count=0; reset pulse while out_valid=1 -> out_valid=0 next cycle.
REQ-045 Saturation: 300 samples with a=b=y=0 and no finish -> count=255, state stays COLLECT.
